// File: rtl/shiftreg_pkg.sv
// Shared constants for the shiftreg_4bit serial delay line.
// Holds the default chain depth and the legal depth bounds checked at elaboration.
package shiftreg_pkg;

  localparam int SHIFTREG_DEFAULT_DEPTH = 4;
  localparam int SHIFTREG_MIN_DEPTH     = 2;
  localparam int SHIFTREG_MAX_DEPTH     = 32;

  function automatic bit depth_in_range(input int depth);
    return (depth >= SHIFTREG_MIN_DEPTH) && (depth <= SHIFTREG_MAX_DEPTH);
  endfunction

endpackage

// File: rtl/shiftreg_stage.sv
// One flip-flop of the serial chain, with a synchronous active-high clear.
// The data path is a plain copy, so X/Z on d reaches q unaltered.
module shiftreg_stage (
  input  logic clock,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic q_d;
  logic q_q;

  // Clear wins over data; no enable, so the stage loads on every edge.
  always_comb begin
    q_d = d;
    if (clear) begin
      q_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignment lets every stage capture its predecessor's
  // pre-edge value, which is what keeps the chain free of bubbles.
  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shiftreg_4bit.sv
// Serial-in, serial-out delay line of DEPTH shiftreg_stage flops (E = last stage).
// Optional macro SHIFTREG_TAPS_EN adds a taps output exposing every stage.
module shiftreg_4bit
  import shiftreg_pkg::*;
#(
  parameter int DEPTH = SHIFTREG_DEFAULT_DEPTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             A,
  output logic             E
`ifdef SHIFTREG_TAPS_EN
  ,
  output logic [DEPTH-1:0] taps
`endif
);

  if (!depth_in_range(DEPTH)) begin : g_depth_check
    $error("shiftreg_4bit: DEPTH=%0d outside %0d..%0d",
           DEPTH, SHIFTREG_MIN_DEPTH, SHIFTREG_MAX_DEPTH);
  end

  logic [DEPTH-1:0] stage_w;
  logic [DEPTH-1:0] chain_in;

  // Stage i is fed by stage i-1; stage 0 is fed by the serial input.
  assign chain_in = {stage_w[DEPTH-2:0], A};

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    shiftreg_stage u_stage (
      .clock (clock),
      .clear (clear),
      .d     (chain_in[i]),
      .q     (stage_w[i])
    );
  end

  assign E = stage_w[DEPTH-1];

`ifdef SHIFTREG_TAPS_EN
  assign taps = stage_w;
`endif

endmodule

// File: tb/tb_shiftreg_4bit.sv
// Self-checking bench for shiftreg_4bit (DEPTH=4): directed literal scenarios
// plus randomized stimulus compared every cycle against a history-queue model.
module tb_shiftreg_4bit;

  localparam int DEPTH = 4;

  logic clock;
  logic clear;
  logic A;
  logic E;
`ifdef SHIFTREG_TAPS_EN
  logic [DEPTH-1:0] taps;
`endif

  int total = 0;
  int bad   = 0;

  shiftreg_4bit #(.DEPTH(DEPTH)) dut (
    .clock (clock),
    .clear (clear),
    .A     (A),
    .E     (E)
`ifdef SHIFTREG_TAPS_EN
    ,
    .taps  (taps)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the last DEPTH bits sampled since the most recent clear,
  // newest at index 0. E is the oldest remembered bit.
  logic hist[$];
  bit   model_valid = 1'b0;

  always @(posedge clock) begin
    if (clear === 1'b1) begin
      hist.delete();
      for (int i = 0; i < DEPTH; i++) hist.push_back(1'b0);
      model_valid = 1'b1;
    end else if (model_valid) begin
      hist.push_front(A);
      void'(hist.pop_back());
    end
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check("model_e", {31'd0, E}, {31'd0, hist[DEPTH-1]});
`ifdef SHIFTREG_TAPS_EN
      begin
        logic [DEPTH-1:0] exp_taps;
        for (int i = 0; i < DEPTH; i++) exp_taps[i] = hist[i];
        check("model_taps", {{(32-DEPTH){1'b0}}, taps}, {{(32-DEPTH){1'b0}}, exp_taps});
      end
`endif
    end
  end

  // Drive just after a rising edge; the values are sampled by the next edge.
  task automatic step(input logic a, input logic clr);
    @(posedge clock);
    #2;
    A     = a;
    clear = clr;
  endtask

  // Drive a bit pattern after a clear and check it emerges DEPTH edges later.
  task automatic run_pattern(input string name, input logic [15:0] pat, input int len);
    logic obs[32];
    step(1'b0, 1'b1);
    for (int j = 0; j < len + DEPTH; j++) begin
      step((j < len) ? pat[j] : 1'b0, 1'b0);
      @(negedge clock);
      obs[j] = E;
    end
    // Bit j is sampled on the edge after step j and reaches E three edges later.
    for (int j = 0; j < len; j++) begin
      check(name, {31'd0, obs[j + DEPTH]}, {31'd0, pat[j]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pat;
    clear = 1'b1;
    A     = 1'b0;

    // Clear on the edge at 5, then A=1 from t=10: first 1 on E after edge 45.
    #10;
    check("reset_e", {31'd0, E}, 32'd0);
    clear = 1'b0;
    A     = 1'b1;
    #30;  // t=40, after edge 35
    check("latency_before", {31'd0, E}, 32'd0);
    #10;  // t=50, after edge 45
    check("latency_first", {31'd0, E}, 32'd1);

    // Chain is full of ones; a single clear edge empties it at once.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    @(negedge clock);
    check("clear_immediate", {31'd0, E}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      @(negedge clock);
      check("clear_stays_zero", {31'd0, E}, 32'd0);
    end

    // Clear held for several edges keeps everything at zero even with A=1.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1);
      @(negedge clock);
      check("clear_held", {31'd0, E}, 32'd0);
    end

    // Five-cycle pulse of ones.
    pat = 16'b0000_0000_0001_1111;
    run_pattern("pulse5", pat, 8);

    // Serial pattern 1,0,1,1,0,0,1 (first bit in bit 0).
    pat = 16'b0000_0000_0100_1101;
    run_pattern("pattern7", pat, 7);

`ifdef SHIFTREG_TAPS_EN
    // Single one walking through the taps.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0);
      @(negedge clock);
      check("taps_walk", {28'd0, taps}, (k < 4) ? (32'd1 << k) : 32'd0);
    end
`endif

    // Randomized traffic with occasional clears, checked by the model process.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    step(1'b0, 1'b0);
    @(negedge clock);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
